hold_sweep_ctrl: RTL and testbench

- Digital controller that sits upstream of the hold-study measurement submodule and closes the loop around it.
- Drives the capacitor-charge code that sets the D-to-CLK skew.
- Consumes the measured clk_rise_time / d_fall_time and the capture pass/fail flag.
- Runs a successive-approximation search for the smallest passing code, then reports the hold time and raises fin_test.

---
 rtl/hold_study_pkg.sv | 13 +
 rtl/hold_sweep_ctrl_if.sv | 25 ++
 rtl/hold_sweep_ctrl_meas_handshake.sv | 43 ++++
 rtl/hold_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hold_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hold_study_pkg.sv
// rtl/hold_study_pkg.sv - shared types, default widths and time helper for the hold-time sweep
package hold_study_pkg;
   localparam int DEF_CODE_W = 8;
   localparam int DEF_TIME_W = 16;

   typedef enum logic [2:0] {IDLE, APPLY, REQ, EVAL, DONE} state_t;
   typedef enum logic [1:0] {P0, P1, SAR} phase_t;

   // Both instants are unsigned; zero-extend before subtracting so the sign carries skew direction.
   function automatic logic signed [32:0] time_diff(input logic [31:0] d_fall, input logic [31:0] clk_rise);
      return $signed({1'b0, d_fall}) - $signed({1'b0, clk_rise});
   endfunction
endpackage

// File: rtl/hold_sweep_ctrl_if.sv
// rtl/hold_sweep_ctrl_if.sv - link between the sweep controller and the hold-study measurement block
interface hold_sweep_ctrl_if
   import hold_study_pkg::*;
#(
   parameter int CODE_W = DEF_CODE_W,
   parameter int TIME_W = DEF_TIME_W
);
   logic [CODE_W-1:0] capa_code;
   logic              meas_req;
   logic              meas_ack;
   logic [TIME_W-1:0] clk_rise_time;
   logic [TIME_W-1:0] d_fall_time;
   logic              q_ok;
   logic              fin_test;

   modport master (
      output capa_code, meas_req, fin_test,
      input  meas_ack, clk_rise_time, d_fall_time, q_ok
   );

   modport slave (
      input  capa_code, meas_req, fin_test,
      output meas_ack, clk_rise_time, d_fall_time, q_ok
   );
endinterface

// File: rtl/hold_sweep_ctrl_meas_handshake.sv
// rtl/hold_sweep_ctrl_meas_handshake.sv - measurement request/ack handshake with capture and ack timeout
module meas_handshake
   import hold_study_pkg::*;
#(
   parameter int TIME_W      = DEF_TIME_W,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_en,
   input  logic                     meas_ack,
   input  logic                     q_ok,
   input  logic [TIME_W-1:0]        clk_rise_time,
   input  logic [TIME_W-1:0]        d_fall_time,
   output logic                     meas_req,
   output logic                     got_meas,
   output logic                     timeout,
   output logic                     q_ok_cap,
   output logic signed [TIME_W:0]   diff_cap
);
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

   logic [TO_W-1:0] wait_cnt;

   // Request follows the REQ state directly so it falls on the same edge the FSM leaves REQ.
   assign meas_req = req_en;
   assign got_meas = req_en && meas_ack;
   assign timeout  = req_en && !meas_ack && (wait_cnt == TO_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         q_ok_cap <= 1'b0;
         diff_cap <= '0;
      end else begin
         wait_cnt <= req_en ? wait_cnt + 1'b1 : '0;
         if (got_meas) begin
            q_ok_cap <= q_ok;
            diff_cap <= (TIME_W+1)'(time_diff(32'(d_fall_time), 32'(clk_rise_time)));
         end
      end
   end
endmodule

// File: rtl/hold_sweep_ctrl.sv
// rtl/hold_sweep_ctrl.sv - successive-approximation search for the smallest capa_code meeting hold
module hold_sweep_ctrl
   import hold_study_pkg::*;
#(
   parameter int CODE_W      = DEF_CODE_W,
   parameter int TIME_W      = DEF_TIME_W,
   parameter int SETTLE_CYC  = 4,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   hold_sweep_ctrl_if.master      mif,
   output logic                   busy,
   output logic                   done,
   output logic [CODE_W-1:0]      hold_code,
   output logic signed [TIME_W:0] hold_time,
   output logic                   err_no_pass,
   output logic                   err_timeout
);
   localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [CODE_W-1:0] CODE_MAX = '1;

   state_t                 state, state_n;
   phase_t                 phase, phase_n;
   logic [CODE_W-1:0]      code_q, code_n, acc_q, acc_n, best_q, best_n, hold_code_n;
   logic signed [TIME_W:0] best_diff_q, best_diff_n, hold_time_n;
   logic [BIT_W-1:0]       bit_q, bit_n;
   logic [7:0]             settle_q, settle_n;
   logic                   err_np_n, err_to_n;
   logic                   got_meas, timeout, q_ok_cap;
   logic signed [TIME_W:0] diff_cap;

   meas_handshake #(.TIME_W(TIME_W), .ACK_TIMEOUT(ACK_TIMEOUT)) u_hs (
      .clk           (clk),
      .rst           (rst),
      .req_en        (state == REQ),
      .meas_ack      (mif.meas_ack),
      .q_ok          (mif.q_ok),
      .clk_rise_time (mif.clk_rise_time),
      .d_fall_time   (mif.d_fall_time),
      .meas_req      (mif.meas_req),
      .got_meas      (got_meas),
      .timeout       (timeout),
      .q_ok_cap      (q_ok_cap),
      .diff_cap      (diff_cap)
   );

   assign busy          = (state != IDLE) && (state != DONE);
   assign done          = (state == DONE);
   assign mif.fin_test  = done;
   assign mif.capa_code = code_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         phase       <= P0;
         code_q      <= '0;
         acc_q       <= '0;
         best_q      <= '0;
         best_diff_q <= '0;
         bit_q       <= '0;
         settle_q    <= '0;
         hold_code   <= '0;
         hold_time   <= '0;
         err_no_pass <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_n;
         phase       <= phase_n;
         code_q      <= code_n;
         acc_q       <= acc_n;
         best_q      <= best_n;
         best_diff_q <= best_diff_n;
         bit_q       <= bit_n;
         settle_q    <= settle_n;
         hold_code   <= hold_code_n;
         hold_time   <= hold_time_n;
         err_no_pass <= err_np_n;
         err_timeout <= err_to_n;
      end
   end

   always_comb begin
      state_n     = state;
      phase_n     = phase;
      code_n      = code_q;
      acc_n       = acc_q;
      best_n      = best_q;
      best_diff_n = best_diff_q;
      bit_n       = bit_q;
      settle_n    = '0;
      hold_code_n = hold_code;
      hold_time_n = hold_time;
      err_np_n    = err_no_pass;
      err_to_n    = err_timeout;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n  = APPLY;
               phase_n  = P0;
               code_n   = '0;
               err_np_n = 1'b0;
               err_to_n = 1'b0;
            end
         end
         APPLY: begin
            if (settle_q == 8'(SETTLE_CYC - 1)) state_n  = REQ;
            else                                settle_n = settle_q + 8'd1;
         end
         REQ: begin
            if (got_meas) begin
               state_n = EVAL;
            end else if (timeout) begin
               err_to_n = 1'b1;
               state_n  = DONE;
            end
         end
         EVAL: begin
            case (phase)
               P0: begin
                  if (q_ok_cap) begin
                     hold_code_n = '0;
                     hold_time_n = diff_cap;
                     state_n     = DONE;
                  end else begin
                     phase_n = P1;
                     code_n  = CODE_MAX;
                     state_n = APPLY;
                  end
               end
               P1: begin
                  if (!q_ok_cap) begin
                     err_np_n    = 1'b1;
                     hold_code_n = CODE_MAX;
                     hold_time_n = diff_cap;
                     state_n     = DONE;
                  end else begin
                     best_n      = CODE_MAX;
                     best_diff_n = diff_cap;
                     acc_n       = '0;
                     bit_n       = BIT_W'(CODE_W - 1);
                     phase_n     = SAR;
                     code_n      = acc_n | (CODE_W'(1) << bit_n);
                     state_n     = APPLY;
                  end
               end
               default: begin
                  // A failing trial keeps its bit; a passing one only competes for best.
                  if (!q_ok_cap) begin
                     acc_n = code_q;
                  end else if (code_q < best_q) begin
                     best_n      = code_q;
                     best_diff_n = diff_cap;
                  end
                  if (bit_q == '0) begin
                     hold_code_n = best_n;
                     hold_time_n = best_diff_n;
                     state_n     = DONE;
                  end else begin
                     bit_n   = bit_q - 1'b1;
                     code_n  = acc_n | (CODE_W'(1) << bit_n);
                     state_n = APPLY;
                  end
               end
            endcase
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_hold_sweep_ctrl.sv
// tb/tb_hold_sweep_ctrl.sv - self-checking bench for hold_sweep_ctrl with a threshold measurement model
module tb_hold_sweep_ctrl;
   localparam int CW = 8;
   localparam int TW = 16;
   localparam int SC = 4;
   localparam int AT = 1023;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done, err_no_pass, err_timeout;
   logic [CW-1:0] hold_code;
   logic signed [TW:0] hold_time;

   hold_sweep_ctrl_if #(.CODE_W(CW), .TIME_W(TW)) mif ();

   hold_sweep_ctrl #(.CODE_W(CW), .TIME_W(TW), .SETTLE_CYC(SC), .ACK_TIMEOUT(AT)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mif         (mif),
      .busy        (busy),
      .done        (done),
      .hold_code   (hold_code),
      .hold_time   (hold_time),
      .err_no_pass (err_no_pass),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int thr;
      int mode;
      int dmax;
      int exp_code;
      int exp_time;
      int exp_meas;
      bit exp_np;
   } vec_t;

   int  n_pass = 0;
   int  n_total = 0;
   int  thr = 100;
   int  mode = 0;
   int  dmax = 0;
   bit  never_ack = 1'b0;
   int  delay_left = -1;
   int  req_cycles = 0;
   int  codes[$];

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Measurement block stand-in: q_ok follows a threshold, ack after a random delay.
   initial begin
      mif.meas_ack      = 1'b0;
      mif.q_ok          = 1'b0;
      mif.clk_rise_time = '0;
      mif.d_fall_time   = '0;
      forever begin
         @(negedge clk);
         mif.meas_ack      = 1'b0;
         mif.q_ok          = 1'($urandom);
         mif.clk_rise_time = 16'($urandom);
         mif.d_fall_time   = 16'($urandom);
         if (rst) begin
            delay_left = -1;
         end else if (mif.meas_req) begin
            req_cycles++;
            if (!never_ack) begin
               if (delay_left < 0) delay_left = int'($urandom_range(dmax, 0));
               if (delay_left == 0) begin
                  mif.meas_ack      = 1'b1;
                  mif.q_ok          = (int'(mif.capa_code) >= thr);
                  mif.clk_rise_time = 16'd1000;
                  mif.d_fall_time   = (mode == 0) ? 16'(1000 + 2 * int'(mif.capa_code)) : 16'd950;
                  codes.push_back(int'(mif.capa_code));
                  delay_left = -1;
               end else begin
                  delay_left--;
               end
            end
         end
      end
   end

   // Reference: smallest passing code by linear scan, measurement count from the search shape.
   function automatic void model(input int m_thr, input int m_mode, output int code, output int t,
                                 output int nmeas, output bit np);
      bit found = 1'b0;
      code = 255;
      for (int c = 0; c < 256; c++) begin
         if (!found && c >= m_thr) begin
            code  = c;
            found = 1'b1;
         end
      end
      np    = !found;
      t     = (m_mode == 0) ? 2 * code : -50;
      nmeas = np ? 2 : ((code == 0) ? 1 : CW + 2);
   endfunction

   task automatic run_search(input int t_thr, input int t_mode, input int t_dmax, input bit spam, output bit ok);
      thr = t_thr; mode = t_mode; dmax = t_dmax; never_ack = 1'b0;
      @(negedge clk);
      codes.delete();
      req_cycles = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (spam && (i == 2 || i == 9 || i == 40)) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic check_result(input string tag, input int e_code, input int e_time, input int e_meas, input bit e_np);
      check({tag, " hold_code"}, hold_code, e_code);
      check({tag, " hold_time"}, longint'(hold_time), e_time);
      check({tag, " meas_count"}, codes.size(), e_meas);
      check({tag, " err_no_pass"}, err_no_pass, e_np);
      check({tag, " err_timeout"}, err_timeout, 0);
      check({tag, " busy/done/fin"}, {busy, done, mif.fin_test}, 3'b011);
   endtask

   initial begin
      vec_t vecs[7];
      int   exp_seq[10];
      bit   ok;
      int   lat, rises, e_code, e_time, e_meas;
      bit   e_np, prev;

      vecs[0] = '{100, 0, 0, 100, 200, 10, 1'b0};
      vecs[1] = '{0, 1, 0, 0, -50, 1, 1'b0};
      vecs[2] = '{300, 0, 3, 255, 510, 2, 1'b1};
      vecs[3] = '{300, 1, 0, 255, -50, 2, 1'b1};
      vecs[4] = '{255, 0, 2, 255, 510, 10, 1'b0};
      vecs[5] = '{1, 0, 1, 1, 2, 10, 1'b0};
      vecs[6] = '{100, 0, 20, 100, 200, 10, 1'b0};
      exp_seq = '{0, 255, 128, 64, 96, 112, 104, 100, 98, 99};

      repeat (3) @(negedge clk);
      check("reset outputs", {busy, done, mif.fin_test, mif.meas_req, err_no_pass, err_timeout}, 0);
      check("reset capa/hold_code", {mif.capa_code, hold_code}, 0);
      check("reset hold_time", longint'(hold_time), 0);
      rst = 1'b0;

      foreach (vecs[k]) begin
         run_search(vecs[k].thr, vecs[k].mode, vecs[k].dmax, 1'b0, ok);
         check($sformatf("vec%0d finished", k), ok, 1);
         check_result($sformatf("vec%0d", k), vecs[k].exp_code, vecs[k].exp_time, vecs[k].exp_meas, vecs[k].exp_np);
         if (k == 0) begin
            for (int j = 0; j < 10; j++)
               check($sformatf("seq[%0d]", j), (j < codes.size()) ? codes[j] : -1, exp_seq[j]);
            check("capa_code held in DONE", mif.capa_code, 99);
         end
      end

      // Settle time between start and the first request
      thr = 0; mode = 1; dmax = 0; never_ack = 1'b0;
      codes.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int i = 0; i < 50; i++) begin
         if (mif.meas_req) break;
         lat++;
         @(negedge clk);
      end
      check("settle cycles", lat, SC);
      for (int i = 0; i < 100 && !done; i++) @(negedge clk);
      check_result("settle", 0, -50, 1, 1'b0);

      // No ack ever arrives
      never_ack = 1'b1;
      req_cycles = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("timeout finished", ok, 1);
      check("timeout req cycles", req_cycles, AT);
      check("timeout flags", {err_timeout, done, busy, mif.meas_req}, 4'b1100);
      never_ack = 1'b0;

      // Reset while the 4th SAR request (6th overall) is pending
      thr = 100; mode = 0; dmax = 5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rises = 0;
      prev = 1'b0;
      for (int i = 0; i < 2000 && rises < 6; i++) begin
         if (mif.meas_req && !prev) rises++;
         prev = mif.meas_req;
         if (rises < 6) @(negedge clk);
      end
      check("reached 6th request", rises, 6);
      rst = 1'b1;
      @(negedge clk);
      check("mid reset outputs", {busy, done, mif.fin_test, mif.meas_req, err_no_pass, err_timeout}, 0);
      check("mid reset codes", {mif.capa_code, hold_code}, 0);
      check("mid reset hold_time", longint'(hold_time), 0);
      rst = 1'b0;
      run_search(100, 0, 7, 1'b0, ok);
      check("after reset finished", ok, 1);
      check_result("after reset", 100, 200, 10, 1'b0);

      // start pulses during APPLY and REQ must not disturb the running search
      run_search(100, 0, int'($urandom_range(20, 0)), 1'b1, ok);
      check("spam finished", ok, 1);
      check_result("spam", 100, 200, 10, 1'b0);
      for (int j = 0; j < 10; j++)
         check($sformatf("spam seq[%0d]", j), (j < codes.size()) ? codes[j] : -1, exp_seq[j]);

      // Random thresholds and ack delays against the reference model
      for (int r = 0; r < 12; r++) begin
         int r_thr, r_mode;
         r_thr  = int'($urandom_range(300, 0));
         r_mode = int'($urandom_range(1, 0));
         model(r_thr, r_mode, e_code, e_time, e_meas, e_np);
         run_search(r_thr, r_mode, int'($urandom_range(20, 0)), 1'b0, ok);
         check($sformatf("rand%0d thr%0d finished", r, r_thr), ok, 1);
         check_result($sformatf("rand%0d thr%0d", r, r_thr), e_code, e_time, e_meas, e_np);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
